// File: rtl/spi_slave_dev.sv
// SPI slave peripheral with an AVR-style SPCR/SPSR/SPDR register view.
// All pins are oversampled in the clk_i domain.
module spi_slave_dev #(
    parameter bit ENABLE      = 1'b1,
    parameter bit WCOL_ENABLE = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ena_i,
    input  logic [5:0] adr_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    input  logic       re_i,
    input  logic       we_i,
    output logic       selected_o,
    output logic       irq_req_o,
    input  logic       irq_ack_i,
    output logic       mux_en_o,
    input  logic       sclk_i,
    input  logic       ss_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_en_o
);

    localparam logic [5:0] SPCR_ADDRESS = 6'h2C;
    localparam logic [5:0] SPSR_ADDRESS = 6'h2D;
    localparam logic [5:0] SPDR_ADDRESS = 6'h2E;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  spcr_q, spcr_d;
    logic [7:0]  tx_r_q, tx_r_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_buf_q, rx_buf_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        spif_q, spif_d;
    logic        wcol_q, wcol_d;
    logic        cpol_q, cpol_d;
    logic        cpha_q, cpha_d;
    logic        dord_q, dord_d;
    logic [2:0]  sclk_q;
    logic [2:0]  ss_q;
    logic [1:0]  mosi_q;

    logic hit_spcr, hit_spsr, hit_spdr;
    logic wr_spcr, wr_spdr, rd_spdr, acc_spdr;
    logic spe, sclk_chg, lead, trail, sample, shift;
    logic ss_fall, ss_rise;
    logic spif_set, wcol_set;
    logic [7:0] rx_next;

    assign hit_spcr = ENABLE && (adr_i == SPCR_ADDRESS);
    assign hit_spsr = ENABLE && (adr_i == SPSR_ADDRESS);
    assign hit_spdr = ENABLE && (adr_i == SPDR_ADDRESS);

    assign wr_spcr  = ena_i & we_i & hit_spcr;
    assign wr_spdr  = ena_i & we_i & hit_spdr;
    assign rd_spdr  = ena_i & re_i & hit_spdr;
    assign acc_spdr = ena_i & (re_i | we_i) & hit_spdr;

    assign selected_o = (hit_spcr | hit_spsr | hit_spdr) & (re_i | we_i);

    always_comb begin
        data_o = '0;
        unique case (1'b1)
            hit_spcr: data_o = spcr_q;
            hit_spsr: data_o = {spif_q, wcol_q, 6'b0};
            hit_spdr: data_o = rx_buf_q;
            default:  data_o = '0;
        endcase
    end

    assign spe       = spcr_q[6];
    assign mux_en_o  = spe;
    assign irq_req_o = ENABLE && spif_q && spcr_q[7];
    assign miso_o    = dord_q ? tx_sh_q[0] : tx_sh_q[7];
    assign miso_en_o = (state_q == ACTIVE);

    // Leading edge leaves the idle level held in the latched CPOL copy.
    assign sclk_chg = sclk_q[1] ^ sclk_q[2];
    assign lead     = sclk_chg & (sclk_q[2] == cpol_q);
    assign trail    = sclk_chg & (sclk_q[2] != cpol_q);
    assign sample   = cpha_q ? trail : lead;
    assign shift    = cpha_q ? lead : trail;
    assign ss_fall  = ss_q[2] & ~ss_q[1];
    assign ss_rise  = ~ss_q[2] & ss_q[1];

    always_comb begin
        state_d   = state_q;
        spcr_d    = spcr_q;
        tx_r_d    = tx_r_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_buf_d  = rx_buf_q;
        bit_cnt_d = bit_cnt_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        dord_d    = dord_q;
        spif_set  = 1'b0;
        wcol_set  = 1'b0;
        rx_next   = dord_q ? {mosi_q[1], rx_sh_q[7:1]}
                           : {rx_sh_q[6:0], mosi_q[1]};

        if (wr_spcr) begin
            spcr_d = data_i & 8'hEF;
        end

        unique case (state_q)
            IDLE: begin
                if (wr_spdr) begin
                    tx_r_d = data_i;
                end
                if (spe && ss_fall) begin
                    state_d   = ACTIVE;
                    cpol_d    = spcr_q[3];
                    cpha_d    = spcr_q[2];
                    dord_d    = spcr_q[5];
                    tx_sh_d   = tx_r_q;
                    rx_sh_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            ACTIVE: begin
                wcol_set = wr_spdr;
                if (!spe || ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (sample) begin
                    rx_sh_d   = rx_next;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_buf_d = rx_next;
                        spif_set = 1'b1;
                        tx_sh_d  = tx_r_q;
                    end
                end else if (shift && bit_cnt_q != 3'd0) begin
                    tx_sh_d = dord_q ? {1'b0, tx_sh_q[7:1]}
                                     : {tx_sh_q[6:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        spif_d = spif_set | (spif_q & ~(irq_ack_i | acc_spdr));
        wcol_d = WCOL_ENABLE && (wcol_set | (wcol_q & ~rd_spdr));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            spcr_q    <= '0;
            tx_r_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_buf_q  <= '0;
            bit_cnt_q <= '0;
            spif_q    <= 1'b0;
            wcol_q    <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            dord_q    <= 1'b0;
            sclk_q    <= 3'b000;
            ss_q      <= 3'b111;
            mosi_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            spcr_q    <= spcr_d;
            tx_r_q    <= tx_r_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_buf_q  <= rx_buf_d;
            bit_cnt_q <= bit_cnt_d;
            spif_q    <= spif_d;
            wcol_q    <= wcol_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            dord_q    <= dord_d;
            sclk_q    <= {sclk_q[1:0], sclk_i};
            ss_q      <= {ss_q[1:0], ss_n_i};
            mosi_q    <= {mosi_q[0], mosi_i};
        end
    end

endmodule

// File: tb/tb_spi_slave_dev.sv
// Directed bench for spi_slave_dev: an SPI master model plus CPU register
// accesses, with hand-computed expected values.
module tb_spi_slave_dev;

    localparam logic [5:0] SPCR = 6'h2C;
    localparam logic [5:0] SPSR = 6'h2D;
    localparam logic [5:0] SPDR = 6'h2E;
    localparam int HALF = 5;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       ena_i = 1'b0;
    logic [5:0] adr_i = '0;
    logic [7:0] data_i = '0;
    logic [7:0] data_o;
    logic       re_i = 1'b0;
    logic       we_i = 1'b0;
    logic       selected_o;
    logic       irq_req_o;
    logic       irq_ack_i = 1'b0;
    logic       mux_en_o;
    logic       sclk_i = 1'b0;
    logic       ss_n_i = 1'b1;
    logic       mosi_i = 1'b0;
    logic       miso_o;
    logic       miso_en_o;

    int total = 0;
    int bad = 0;
    logic cpol = 1'b0, cpha = 1'b0, dord = 1'b0;
    logic [7:0] mtx = '0, mrx = '0, r;
    logic [2:0] mv;

    spi_slave_dev dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ena_i(ena_i),
        .adr_i(adr_i), .data_i(data_i), .data_o(data_o),
        .re_i(re_i), .we_i(we_i), .selected_o(selected_o),
        .irq_req_o(irq_req_o), .irq_ack_i(irq_ack_i),
        .mux_en_o(mux_en_o), .sclk_i(sclk_i), .ss_n_i(ss_n_i),
        .mosi_i(mosi_i), .miso_o(miso_o), .miso_en_o(miso_en_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [5:0] a, input logic [7:0] d);
        adr_i = a; data_i = d; ena_i = 1'b1; we_i = 1'b1;
        cyc(1);
        ena_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic cpu_rd(input logic [5:0] a, output logic [7:0] d);
        adr_i = a; ena_i = 1'b1; re_i = 1'b1;
        #1 d = data_o;
        cyc(1);
        ena_i = 1'b0; re_i = 1'b0;
    endtask

    task automatic ack();
        irq_ack_i = 1'b1;
        cyc(1);
        irq_ack_i = 1'b0;
    endtask

    // Master: bits are numbered in transmission order.
    task automatic bits(input int from, input int to);
        int b;
        for (int i = from; i <= to; i++) begin
            b = dord ? i : 7 - i;
            if (!cpha) begin
                mosi_i = mtx[b];
                cyc(HALF);
                sclk_i = ~cpol;
                mrx[b] = miso_o;
                cyc(HALF);
                sclk_i = cpol;
            end else begin
                sclk_i = ~cpol;
                mosi_i = mtx[b];
                cyc(HALF);
                sclk_i = cpol;
                mrx[b] = miso_o;
                cyc(HALF);
            end
        end
    endtask

    task automatic frame(input logic [7:0] tx);
        mtx = tx;
        ss_n_i = 1'b0;
        cyc(6);
        bits(0, 7);
        cyc(HALF);
        ss_n_i = 1'b1;
        cyc(6);
    endtask

    initial begin
        cyc(2);
        chk("rst_miso", {7'd0, miso_o}, 8'h00);
        chk("rst_miso_en", {7'd0, miso_en_o}, 8'h00);
        chk("rst_irq", {7'd0, irq_req_o}, 8'h00);
        chk("rst_mux_en", {7'd0, mux_en_o}, 8'h00);
        rst_ni = 1'b1;
        cyc(2);
        cpu_rd(SPCR, r); chk("rst_spcr", r, 8'h00);
        cpu_rd(SPSR, r); chk("rst_spsr", r, 8'h00);
        cpu_rd(SPDR, r); chk("rst_spdr", r, 8'h00);

        adr_i = SPDR; re_i = 1'b1;
        #1 chk("selected_hit", {7'd0, selected_o}, 8'h01);
        adr_i = 6'h05;
        #1 chk("selected_miss", {7'd0, selected_o}, 8'h00);
        chk("data_miss", data_o, 8'h00);
        cyc(1); re_i = 1'b0;

        // Mode 0, MSB first
        cpu_wr(SPCR, 8'hD0);
        cpu_rd(SPCR, r); chk("spcr_mstr_masked", r, 8'hC0);
        chk("mux_en", {7'd0, mux_en_o}, 8'h01);
        cpu_wr(SPDR, 8'hA5);
        frame(8'h3C);
        chk("m0_master_rx", mrx, 8'hA5);
        cpu_rd(SPSR, r); chk("m0_spsr", r, 8'h80);
        chk("m0_irq", {7'd0, irq_req_o}, 8'h01);
        ack(); cyc(1);
        cpu_rd(SPSR, r); chk("m0_ack_spsr", r, 8'h00);
        chk("m0_ack_irq", {7'd0, irq_req_o}, 8'h00);
        cpu_rd(SPDR, r); chk("m0_spdr", r, 8'h3C);

        for (int m = 0; m < 8; m++) begin
            mv = m[2:0];
            cpol = mv[1]; cpha = mv[0]; dord = mv[2];
            sclk_i = cpol;
            cyc(6);
            cpu_wr(SPCR, {2'b01, dord, 1'b0, cpol, cpha, 2'b00});
            cpu_wr(SPDR, 8'h81);
            frame(8'h7E);
            chk($sformatf("mode%0d_master_rx", m), mrx, 8'h81);
            cpu_rd(SPSR, r); chk($sformatf("mode%0d_spsr", m), r, 8'h80);
            cpu_rd(SPDR, r); chk($sformatf("mode%0d_spdr", m), r, 8'h7E);
        end

        // LSB first with an asymmetric pattern
        cpol = 1'b0; cpha = 1'b0; dord = 1'b1;
        sclk_i = 1'b0;
        cyc(6);
        cpu_wr(SPCR, 8'h60);
        cpu_wr(SPDR, 8'h0F);
        frame(8'h35);
        chk("lsb_master_rx", mrx, 8'h0F);
        cpu_rd(SPDR, r); chk("lsb_spdr", r, 8'h35);

        // Back-to-back, tx_r resent
        dord = 1'b0;
        cpu_wr(SPCR, 8'h40);
        cpu_wr(SPDR, 8'h5A);
        ss_n_i = 1'b0;
        cyc(6);
        mtx = 8'h11; bits(0, 7); chk("b2b_rx0", mrx, 8'h5A);
        mtx = 8'h22; bits(0, 7); chk("b2b_rx1", mrx, 8'h5A);
        mtx = 8'h33; bits(0, 7); chk("b2b_rx2", mrx, 8'h5A);
        cyc(HALF);
        ss_n_i = 1'b1;
        cyc(6);
        cpu_rd(SPSR, r); chk("b2b_spsr", r, 8'h80);
        cpu_rd(SPDR, r); chk("b2b_spdr", r, 8'h33);

        // Aborted frame after 5 bits
        ss_n_i = 1'b0;
        cyc(6);
        mtx = 8'hFF; bits(0, 4);
        ss_n_i = 1'b1;
        cyc(3);
        chk("abort_miso_en", {7'd0, miso_en_o}, 8'h00);
        cyc(3);
        cpu_rd(SPSR, r); chk("abort_spsr", r, 8'h00);
        cpu_rd(SPDR, r); chk("abort_spdr", r, 8'h33);
        cpu_wr(SPDR, 8'hC3);
        frame(8'h96);
        chk("abort_next_rx", mrx, 8'hC3);
        cpu_rd(SPDR, r); chk("abort_next_spdr", r, 8'h96);

        // Write collision
        cpu_wr(SPDR, 8'h24);
        ss_n_i = 1'b0;
        cyc(6);
        mtx = 8'h11; bits(0, 2);
        cpu_wr(SPDR, 8'hFF);
        cpu_rd(SPSR, r); chk("wcol_set", r, 8'h40);
        bits(3, 7);
        cyc(HALF);
        ss_n_i = 1'b1;
        cyc(6);
        chk("wcol_tx_kept", mrx, 8'h24);
        cpu_rd(SPSR, r); chk("wcol_spsr", r, 8'hC0);
        cpu_rd(SPDR, r); chk("wcol_spdr", r, 8'h11);
        cpu_rd(SPSR, r); chk("wcol_clear", r, 8'h00);

        // SPIF set in the same cycle as irq_ack
        ss_n_i = 1'b0;
        cyc(6);
        mtx = 8'h00; bits(0, 6);
        mosi_i = 1'b0;
        cyc(HALF);
        sclk_i = 1'b1;
        cyc(2);
        irq_ack_i = 1'b1;
        cyc(1);
        irq_ack_i = 1'b0;
        cyc(2);
        sclk_i = 1'b0;
        cyc(HALF);
        ss_n_i = 1'b1;
        cyc(6);
        cpu_rd(SPSR, r); chk("set_wins_spsr", r, 8'h80);
        cpu_rd(SPDR, r); chk("set_wins_spdr", r, 8'h00);

        // SPE cleared mid-frame
        ss_n_i = 1'b0;
        cyc(6);
        mtx = 8'hE7; bits(0, 3);
        cpu_wr(SPCR, 8'h00);
        cyc(1);
        chk("spe_off_miso_en", {7'd0, miso_en_o}, 8'h00);
        chk("spe_off_mux_en", {7'd0, mux_en_o}, 8'h00);
        bits(4, 7);
        cyc(HALF);
        ss_n_i = 1'b1;
        cyc(6);
        cpu_rd(SPSR, r); chk("spe_off_spsr", r, 8'h00);
        cpu_rd(SPDR, r); chk("spe_off_spdr", r, 8'h00);

        // Reset mid-frame
        cpu_wr(SPCR, 8'hC0);
        cpu_wr(SPDR, 8'h99);
        ss_n_i = 1'b0;
        cyc(6);
        mtx = 8'h00; bits(0, 3);
        chk("pre_rst_miso_en", {7'd0, miso_en_o}, 8'h01);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_miso_en", {7'd0, miso_en_o}, 8'h00);
        chk("rst_mid_miso", {7'd0, miso_o}, 8'h00);
        chk("rst_mid_mux_en", {7'd0, mux_en_o}, 8'h00);
        chk("rst_mid_irq", {7'd0, irq_req_o}, 8'h00);
        cyc(2);
        ss_n_i = 1'b1;
        sclk_i = 1'b0;
        rst_ni = 1'b1;
        cyc(2);
        cpu_rd(SPCR, r); chk("rst_mid_spcr", r, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
